// File: rtl/duty_seq_multi_if.sv
// rtl/duty_seq_multi_if.sv - control and status bundle for the multi-channel duty sequencer
interface duty_seq_multi_if #(
    parameter int CHANNELS = 4,
    parameter int STEPS    = 4,
    parameter int DUTY_W   = 2,
    parameter int TIMER_W  = 20
);
    localparam int SW = $clog2(STEPS);

    logic                      en;
    logic [CHANNELS-1:0]       note_on;
    logic [CHANNELS-1:0]       note_repeat;
    logic [7*CHANNELS-1:0]     note;
    logic [DUTY_W*STEPS-1:0]   step_duty;
    logic [TIMER_W*STEPS-1:0]  step_len;
    logic                      loop_en;
    logic [SW-1:0]             loop_start;
    logic [DUTY_W*CHANNELS-1:0] duty_out;
    logic [SW*CHANNELS-1:0]    step_out;
    logic [CHANNELS-1:0]       active;
    logic [CHANNELS-1:0]       seq_done;

    modport master (
        output en, note_on, note_repeat, note, step_duty, step_len, loop_en, loop_start,
        input  duty_out, step_out, active, seq_done
    );

    modport slave (
        input  en, note_on, note_repeat, note, step_duty, step_len, loop_en, loop_start,
        output duty_out, step_out, active, seq_done
    );
endinterface

// File: rtl/duty_seq_multi.sv
// rtl/duty_seq_multi.sv - per-voice duty table sequencer with terminal/loop modes
module duty_seq_multi #(
    parameter int CHANNELS  = 4,
    parameter int STEPS     = 4,
    parameter int DUTY_W    = 2,
    parameter int TIMER_W   = 20,
    parameter int IDLE_DUTY = 2
) (
    input  logic              clk,
    input  logic              reset,
    duty_seq_multi_if.slave   bus
);
    localparam int SW = $clog2(STEPS);
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t              st_q    [CHANNELS];
    state_t              st_d    [CHANNELS];
    logic [SW-1:0]       step_q  [CHANNELS];
    logic [SW-1:0]       step_d  [CHANNELS];
    logic [TIMER_W-1:0]  timer_q [CHANNELS];
    logic [TIMER_W-1:0]  timer_d [CHANNELS];
    logic [DUTY_W-1:0]   duty_q  [CHANNELS];
    logic [DUTY_W-1:0]   duty_d  [CHANNELS];
    logic [6:0]          note_q  [CHANNELS];
    logic [6:0]          note_d  [CHANNELS];
    logic                done_q  [CHANNELS];
    logic                done_d  [CHANNELS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                st_q[c]    <= IDLE;
                step_q[c]  <= '0;
                timer_q[c] <= '0;
                duty_q[c]  <= DUTY_W'(IDLE_DUTY);
                note_q[c]  <= '0;
                done_q[c]  <= 1'b0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                st_q[c]    <= st_d[c];
                step_q[c]  <= step_d[c];
                timer_q[c] <= timer_d[c];
                duty_q[c]  <= duty_d[c];
                note_q[c]  <= note_d[c];
                done_q[c]  <= done_d[c];
            end
        end
    end

    // Priority per en tick: gate off, then (re)trigger, then step timing.
    always_comb begin
        logic          trig;
        logic [SW-1:0] nxt;
        for (int c = 0; c < CHANNELS; c++) begin
            st_d[c]    = st_q[c];
            step_d[c]  = step_q[c];
            timer_d[c] = timer_q[c];
            duty_d[c]  = duty_q[c];
            note_d[c]  = note_q[c];
            done_d[c]  = 1'b0;
            trig = bus.note_on[c] &&
                   ((bus.note[7*c +: 7] != note_q[c]) || bus.note_repeat[c] || (st_q[c] == IDLE));
            nxt  = (step_q[c] == LAST) ? bus.loop_start : step_q[c] + 1'b1;
            if (bus.en) begin
                if (!bus.note_on[c]) begin
                    st_d[c]   = IDLE;
                    note_d[c] = '0;
                end else if (trig) begin
                    st_d[c]    = RUN;
                    step_d[c]  = '0;
                    duty_d[c]  = bus.step_duty[0 +: DUTY_W];
                    timer_d[c] = bus.step_len[0 +: TIMER_W];
                    note_d[c]  = bus.note[7*c +: 7];
                end else if (st_q[c] == RUN) begin
                    if (timer_q[c] == '0) begin
                        st_d[c]   = HOLD;
                        done_d[c] = 1'b1;
                    end else if (timer_q[c] == TIMER_W'(1)) begin
                        if ((step_q[c] == LAST) && !bus.loop_en) begin
                            st_d[c]   = HOLD;
                            done_d[c] = 1'b1;
                        end else begin
                            step_d[c]  = nxt;
                            duty_d[c]  = bus.step_duty[DUTY_W*int'(nxt) +: DUTY_W];
                            timer_d[c] = bus.step_len[TIMER_W*int'(nxt) +: TIMER_W];
                        end
                    end else begin
                        timer_d[c] = timer_q[c] - 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign bus.duty_out[DUTY_W*g +: DUTY_W] = duty_q[g];
        assign bus.step_out[SW*g +: SW]         = step_q[g];
        assign bus.active[g]                    = (st_q[g] == RUN);
        assign bus.seq_done[g]                  = done_q[g];
    end
endmodule

// File: tb/tb_duty_seq_multi.sv
// tb/tb_duty_seq_multi.sv - randomized and directed bench for duty_seq_multi
module tb_duty_seq_multi;
    localparam int CH = 4;
    localparam int ST = 4;
    localparam int DW = 2;
    localparam int TW = 20;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    duty_seq_multi_if #(.CHANNELS(CH), .STEPS(ST), .DUTY_W(DW), .TIMER_W(TW)) bus();

    duty_seq_multi #(.CHANNELS(CH), .STEPS(ST), .DUTY_W(DW), .TIMER_W(TW), .IDLE_DUTY(2)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    // Model: each channel owes max(L,1) ticks to the step it just loaded.
    int m_st   [CH];
    int m_step [CH];
    int m_duty [CH];
    int m_owed [CH];
    bit m_term [CH];
    int m_note [CH];
    bit m_done [CH];

    int exp2 [10] = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 3};
    int exp3 [14] = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 1, 1, 2, 3};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_st[c] = M_IDLE; m_step[c] = 0; m_duty[c] = 2;
            m_owed[c] = 0; m_term[c] = 1'b0; m_note[c] = 0; m_done[c] = 1'b0;
        end
    endtask

    task automatic model_load(input int c, input int s);
        int len;
        len = int'(bus.step_len[TW*s +: TW]);
        m_step[c] = s;
        m_duty[c] = int'(bus.step_duty[DW*s +: DW]);
        m_owed[c] = (len == 0) ? 1 : len;
        m_term[c] = (len == 0);
    endtask

    task automatic tick_model();
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < CH; c++) begin
            m_done[c] = 1'b0;
            if (!bus.en) continue;
            if (!bus.note_on[c]) begin
                m_st[c] = M_IDLE;
                m_note[c] = 0;
            end else if (m_st[c] == M_IDLE || int'(bus.note[7*c +: 7]) != m_note[c] || bus.note_repeat[c]) begin
                m_note[c] = int'(bus.note[7*c +: 7]);
                m_st[c] = M_RUN;
                model_load(c, 0);
            end else if (m_st[c] == M_RUN) begin
                m_owed[c]--;
                if (m_owed[c] == 0) begin
                    if (m_term[c] || (m_step[c] == ST - 1 && !bus.loop_en)) begin
                        m_st[c] = M_HOLD;
                        m_done[c] = 1'b1;
                    end else begin
                        model_load(c, (m_step[c] == ST - 1) ? int'(bus.loop_start) : m_step[c] + 1);
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        tick_model();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int c = 0; c < CH; c++) begin
                chk($sformatf("duty[%0d]", c), int'(bus.duty_out[DW*c +: DW]), m_duty[c]);
                chk($sformatf("step[%0d]", c), int'(bus.step_out[2*c +: 2]), m_step[c]);
                chk($sformatf("active[%0d]", c), int'(bus.active[c]), int'(m_st[c] == M_RUN));
                chk($sformatf("seq_done[%0d]", c), int'(bus.seq_done[c]), int'(m_done[c]));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.note_on = '0; bus.note_repeat = '0; bus.note = '0;
        bus.step_duty = {2'd3, 2'd2, 2'd1, 2'd0};
        bus.step_len  = {20'd0, 20'd1, 20'd2, 20'd3};
        bus.loop_en = 1'b0; bus.loop_start = '0;
        model_reset();
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_duty", int'(bus.duty_out), 'haa);
        chk("rst_active", int'(bus.active), 0);
        chk("rst_step", int'(bus.step_out), 0);
        rst = 1'b0;

        // One-shot table: 0x3,1x2,2x1 then terminal 3
        bus.en = 1'b1; bus.note[6:0] = 7'd60; bus.note_on[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk($sformatf("t2_duty[%0d]", i), int'(bus.duty_out[1:0]), exp2[i]);
            chk($sformatf("t2_done[%0d]", i), int'(bus.seq_done[0]), int'(i == 7));
        end
        chk("t2_hold_active", int'(bus.active[0]), 0);
        bus.note_on = '0;
        cycle(); cycle();

        // Looping table back to step 1
        bus.step_len = {20'd4, 20'd1, 20'd2, 20'd3};
        bus.loop_en = 1'b1; bus.loop_start = 2'd1;
        bus.note_on[0] = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cycle();
            chk($sformatf("t3_duty[%0d]", i), int'(bus.duty_out[1:0]), exp3[i]);
        end

        // Async reset with ch0 at step 2
        bus.note_repeat[0] = 1'b1; cycle(); bus.note_repeat[0] = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("t1_pre_step", int'(bus.step_out[1:0]), 2);
        #2 rst = 1'b1;
        #1 model_reset();
        chk("t1_duty", int'(bus.duty_out), 'haa);
        chk("t1_active", int'(bus.active), 0);
        chk("t1_step", int'(bus.step_out), 0);
        cycle();
        rst = 1'b0;
        bus.note_on = '0; bus.loop_en = 1'b0; bus.loop_start = '0;
        bus.step_len = {20'd0, 20'd1, 20'd2, 20'd3};
        cycle(); cycle();

        // ch1 note change then repeat
        bus.note[13:7] = 7'd60; bus.note_on[1] = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("t4_pre_step", int'(bus.step_out[3:2]), 2);
        bus.note[13:7] = 7'd62; cycle();
        chk("t4_note_step", int'(bus.step_out[3:2]), 0);
        chk("t4_note_duty", int'(bus.duty_out[3:2]), 0);
        for (int i = 0; i < 4; i++) cycle();
        chk("t4_mid_step", int'(bus.step_out[3:2]), 1);
        bus.note_repeat[1] = 1'b1; cycle(); bus.note_repeat[1] = 1'b0;
        chk("t4_rep_step", int'(bus.step_out[3:2]), 0);
        chk("t4_rep_duty", int'(bus.duty_out[3:2]), 0);

        // ch2 release wins over repeat on the same tick
        bus.note_on = '0; cycle();
        bus.note[20:14] = 7'd60; bus.note_on[2] = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("t5_pre_duty", int'(bus.duty_out[5:4]), 1);
        bus.note_on[2] = 1'b0; bus.note_repeat[2] = 1'b1; cycle(); bus.note_repeat[2] = 1'b0;
        chk("t5_off_active", int'(bus.active[2]), 0);
        chk("t5_off_duty", int'(bus.duty_out[5:4]), 1);
        bus.note_on[2] = 1'b1; cycle();
        chk("t5_re_duty", int'(bus.duty_out[5:4]), 0);
        chk("t5_re_step", int'(bus.step_out[5:4]), 0);
        chk("t5_re_active", int'(bus.active[2]), 1);

        // Sparse enable, all channels together, gate noise while en=0
        bus.note_on = '0; cycle();
        for (int c = 0; c < CH; c++) bus.note[7*c +: 7] = 7'(40 + c);
        for (int k = 0; k < 80; k++) begin
            bus.en = (k % 4 == 0);
            bus.note_on = bus.en ? 4'hf : 4'($urandom);
            cycle();
        end

        // Randomized traffic with live table changes
        for (int k = 0; k < 2000; k++) begin
            bus.en = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 30) == 0) bus.note_on[c] = ~bus.note_on[c];
                bus.note_repeat[c] = ($urandom_range(0, 40) == 0);
                if ($urandom_range(0, 50) == 0) bus.note[7*c +: 7] = 7'(60 + $urandom_range(0, 1));
            end
            if ($urandom_range(0, 60) == 0) begin
                for (int s = 0; s < ST; s++) begin
                    bus.step_duty[DW*s +: DW] = 2'($urandom);
                    bus.step_len[TW*s +: TW]  = 20'($urandom_range(0, 4));
                end
                bus.loop_en = 1'($urandom);
                bus.loop_start = 2'($urandom);
            end
            cycle();
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
